// File: rtl/inst_block_cache.sv
// Direct-mapped, read-only instruction block cache returning a whole 128-byte block per fetch PC.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module inst_block_cache #(
   parameter int LINES      = 8,
   parameter int BLOCK_BITS = 1024,
   parameter int WORD_SIZE  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           in,
   output logic [BLOCK_BITS-1:0] out,
   output logic                  hit,
   output logic                  mem_req,
   output logic [31:0]           mem_addr,
   input  logic                  mem_rvalid,
   input  logic [WORD_SIZE-1:0]  mem_rdata
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
`endif
);

   localparam int OFF_W  = 7;
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = 32 - OFF_W - IDX_W;
   localparam int BEATS  = BLOCK_BITS / WORD_SIZE;
   localparam int BEAT_W = $clog2(BEATS);
   localparam int LSB_W  = $clog2(BLOCK_BITS);

   typedef enum logic [1:0] {S_IDLE, S_REFILL, S_COMMIT} state_t;

   state_t                state_q, state_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic                  mem_req_q, mem_req_d;
   logic [31:0]           mem_addr_q, mem_addr_d;
   logic                  hit_q, hit_d;
   logic [BLOCK_BITS-1:0] out_q, out_d;
   logic [31:OFF_W]       in_q;
   logic                  in_vld_q;
   logic [LINES-1:0]      valid_q;
   logic [TAG_W-1:0]      tag_mem [LINES];
   logic [BLOCK_BITS-1:0] data_mem [LINES];
   logic [BLOCK_BITS-1:0] rd_data_q;
   logic [BLOCK_BITS-1:0] fill_buf_q;
   logic                  accept, commit, lookup_en, lookup_hit;
   logic [IDX_W-1:0]      lookup_idx, in_idx, fill_idx;
   logic [TAG_W-1:0]      lookup_tag, fill_tag;
   logic [LSB_W-1:0]      fill_lsb;
   logic                  unused_offset;

   assign unused_offset = ^in[OFF_W-1:0];
   assign in_idx     = in[OFF_W +: IDX_W];
   assign lookup_idx = in_q[OFF_W +: IDX_W];
   assign lookup_tag = in_q[31 -: TAG_W];
   assign fill_idx   = mem_addr_q[OFF_W +: IDX_W];
   assign fill_tag   = mem_addr_q[31 -: TAG_W];
   assign lookup_en  = (state_q == S_IDLE) && in_vld_q;
   assign lookup_hit = valid_q[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
   // Word 0 sits in the most significant slot of the block.
   assign fill_lsb   = LSB_W'((BEATS - 1 - int'(beat_q)) * WORD_SIZE);

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      hit_d      = 1'b0;
      out_d      = out_q;
      accept     = 1'b0;
      commit     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (lookup_en) begin
               if (lookup_hit) begin
                  hit_d = 1'b1;
                  out_d = rd_data_q;
               end else begin
                  state_d    = S_REFILL;
                  mem_req_d  = 1'b1;
                  mem_addr_d = {in_q, {OFF_W{1'b0}}};
                  beat_d     = '0;
               end
            end
         end
         S_REFILL: begin
            if (mem_rvalid) begin
               accept = 1'b1;
               beat_d = beat_q + 1'b1;
               if (beat_q == BEAT_W'(BEATS - 1)) begin
                  state_d   = S_COMMIT;
                  mem_req_d = 1'b0;
               end
            end
         end
         S_COMMIT: begin
            commit  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         beat_q     <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         hit_q      <= 1'b0;
         out_q      <= '0;
         in_q       <= '0;
         in_vld_q   <= 1'b0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         hit_q      <= hit_d;
         out_q      <= out_d;
         in_q       <= in[31:OFF_W];
         in_vld_q   <= 1'b1;
         if (commit) valid_q[fill_idx] <= 1'b1;
      end
   end

   // Read port forwards the line being committed so the first IDLE lookup sees fresh data.
   always_ff @(posedge clk) begin
      if (accept) fill_buf_q[fill_lsb +: WORD_SIZE] <= mem_rdata;
      if (commit) begin
         tag_mem[fill_idx]  <= fill_tag;
         data_mem[fill_idx] <= fill_buf_q;
      end
      rd_data_q <= (commit && (in_idx == fill_idx)) ? fill_buf_q : data_mem[in_idx];
   end

   assign out      = out_q;
   assign hit      = hit_q;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count_q, miss_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else if (lookup_en) begin
         if (lookup_hit) hit_count_q  <= hit_count_q + 32'd1;
         else            miss_count_q <= miss_count_q + 32'd1;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_inst_block_cache.sv
// Directed bench for inst_block_cache: refills, hits, conflicts, stalls and mid-refill reset.
module tb_inst_block_cache;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [31:0]   pc = 32'h0;
   logic [1023:0] out;
   logic          hit;
   logic          mem_req;
   logic [31:0]   mem_addr;
   logic          mem_rvalid = 1'b0;
   logic [31:0]   mem_rdata = 32'h0;
`ifdef ICACHE_STATS_EN
   logic [31:0]   hit_count, miss_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   inst_block_cache dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (pc),
      .out        (out),
      .hit        (hit),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] pc;
      logic [31:0] base;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] base, input int k);
      return 32'h1000_0000 + ((base >> 7) << 8) + k;
   endfunction

   function automatic logic [1023:0] blk(input logic [31:0] base);
      logic [1023:0] b;
      b = '0;
      for (int k = 0; k < 32; k++) b[1023 - 32*k -: 32] = word_of(base, k);
      return b;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else
         $display("[TB] ok   %s = 0x%0h", name, act);
   endtask

   task automatic check_blk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
      int bad;
      bad = -1;
      n_tests++;
      for (int k = 31; k >= 0; k--)
         if (act[1023 - 32*k -: 32] !== exp[1023 - 32*k -: 32]) bad = k;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s: word %0d got 0x%0h, expected 0x%0h", name, bad,
                  act[1023 - 32*bad -: 32], exp[1023 - 32*bad -: 32]);
      end else
         $display("[TB] ok   %s block matches", name);
   endtask

   // Waits for a request, checks its address, then supplies beats 0..stop_beat-1.
   task automatic refill(input logic [31:0] base, input bit gaps, input int stop_beat,
                         input int sw_beat, input logic [31:0] sw_pc);
      int  waited;
      int  k;
      bit  toggle;
      bit  hit_low;
      bit  req_ok;
      waited  = 0;
      k       = 0;
      toggle  = gaps;
      hit_low = 1'b1;
      req_ok  = 1'b1;
      while (!mem_req && waited < 20) begin
         tick();
         waited++;
      end
      check("req_rise", mem_req, 1);
      check("mem_addr", mem_addr, base);
      while (k < stop_beat) begin
         if (k == sw_beat) pc = sw_pc;
         if (toggle) begin
            mem_rvalid = 1'b0;
         end else begin
            mem_rvalid = 1'b1;
            mem_rdata  = word_of(base, k);
            k++;
         end
         if (gaps) toggle = !toggle;
         tick();
         if (hit) hit_low = 1'b0;
         if (k < 32 && !mem_req) req_ok = 1'b0;
      end
      mem_rvalid = 1'b0;
      check("hit_low_refill", hit_low, 1);
      check("req_held", req_ok, 1);
      if (stop_beat == 32) check("req_drop", mem_req, 0);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{32'h0000_0004, 32'h0000_0000};
      vecs[1] = '{32'h0000_007C, 32'h0000_0000};
      vecs[2] = '{32'h0000_0090, 32'h0000_0080};
      vecs[3] = '{32'h0000_017F, 32'h0000_0100};
      vecs[4] = '{32'h0000_00FF, 32'h0000_0080};
      vecs[5] = '{32'h0000_0000, 32'h0000_0000};

      #2 rst_n = 1'b0;
      #1;
      check("rst_hit", hit, 0);
      check("rst_req", mem_req, 0);
      check("rst_addr", mem_addr, 0);
      check_blk("rst_out", out, '0);
      tick();
      tick();
      rst_n = 1'b1;
      pc    = 32'h0;

      // Cold miss
      refill(32'h0, 1'b0, 32, -1, 32'h0);
      tick();
      check("hit_commit_cycle", hit, 0);
      tick();
      check("cold_hit", hit, 1);
      check("cold_w0", out[1023:992], 32'h1000_0000);
      check("cold_w31", out[31:0], 32'h1000_001F);
      check_blk("cold_out", out, blk(32'h0));
      tick();
      tick();
`ifdef ICACHE_STATS_EN
      check("stat_hits", hit_count, 3);
      check("stat_miss", miss_count, 1);
`endif

      // Warm hit, offset ignored
      pc = 32'h0000_0044;
      tick();
      check("warm_hit1", hit, 1);
      tick();
      check("warm_hit2", hit, 1);
      check("warm_req", mem_req, 0);
      check_blk("warm_out", out, blk(32'h0));

      // Stalled refill with pc change mid-refill
      pc = 32'h0000_0080;
      refill(32'h80, 1'b1, 32, 10, 32'h0000_0100);
      refill(32'h100, 1'b0, 32, -1, 32'h0);
      tick();
      tick();
      check("after_stall_hit", hit, 1);
      check_blk("after_stall_out", out, blk(32'h100));

      // Table of hits across filled lines
      for (int i = 0; i < 6; i++) begin
         pc = vecs[i].pc;
         tick();
         tick();
         check($sformatf("vec%0d_hit", i), hit, 1);
         check($sformatf("vec%0d_req", i), mem_req, 0);
         check_blk($sformatf("vec%0d_out", i), out, blk(vecs[i].base));
      end

      // Conflict eviction on index 0
      pc = 32'h0000_0400;
      refill(32'h400, 1'b0, 32, -1, 32'h0);
      tick();
      tick();
      check("conf_hit", hit, 1);
      check_blk("conf_out", out, blk(32'h400));
      pc = 32'h0;
      refill(32'h0, 1'b0, 32, -1, 32'h0);
      tick();
      tick();
      check("refill0_hit", hit, 1);
      check_blk("refill0_out", out, blk(32'h0));

      // Reset in the middle of a refill
      pc = 32'h0000_0180;
      refill(32'h180, 1'b0, 5, -1, 32'h0);
      rst_n = 1'b0;
      #1;
      check("midrst_req", mem_req, 0);
      check("midrst_hit", hit, 0);
      tick();
      tick();
      rst_n = 1'b1;
      pc    = 32'h0;
      refill(32'h0, 1'b0, 32, -1, 32'h0);
      tick();
      tick();
      check("post_rst_hit", hit, 1);
      check_blk("post_rst_out", out, blk(32'h0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
